uart_receive: RTL and testbench

Serial-to-parallel UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the host-to-board end of the serial link and sits between the `rx` pad and the command/input logic of the game. Sampling is oversampled by a clock count per bit and matches the transmit path's `clockperbit` convention. A received byte is held with a valid/acknowledge handshake, and framing and overrun errors are flagged.

---
 rtl/uart_receive.sv | 136 +++++++++++++
 tb/tb_uart_receive.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receive.sv
// uart_receive: 8N1 serial receiver (start, 8 data bits LSB first, stop).
// The line is oversampled at clockperbit clocks per bit and sampled mid-bit.
// A received byte is held under a valid/ack handshake. Framing errors give a
// one-cycle pulse. A lost byte sets a sticky overrun flag.
module uart_receive #(
  parameter int unsigned clockperbit = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rxdata,
  output logic       rxvalid,
  input  logic       rxack,
  output logic       rxerror,
  output logic       rxoverrun
);

  // Counter reload values: half a bit to reach the start-bit midpoint,
  // then a full bit between successive mid-bit samples.
  localparam logic [15:0] HalfLoad = 16'(clockperbit / 2 - 1);
  localparam logic [15:0] FullLoad = 16'(clockperbit - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e      state;
  logic [15:0] cnt;
  logic [3:0]  index;
  logic [7:0]  shift;
  logic        rx_meta;
  logic        rxs;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM with registered outputs and the valid/ack/overrun handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      cnt       <= 16'd0;
      index     <= 4'd0;
      shift     <= 8'h00;
      rxdata    <= 8'h00;
      rxvalid   <= 1'b0;
      rxerror   <= 1'b0;
      rxoverrun <= 1'b0;
    end else begin
      rxerror <= 1'b0;

      // Ack of a held byte; a completion below in the same cycle overrides
      // rxvalid, so the ack retires the old byte while the new one is kept.
      if (rxack && rxvalid) begin
        rxvalid   <= 1'b0;
        rxoverrun <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (!rxs) begin
            cnt   <= HalfLoad;
            state <= StStart;
          end
        end

        StStart: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (rxs) begin
            // Start bit did not hold to its midpoint: treat as a glitch.
            state <= StIdle;
          end else begin
            cnt   <= FullLoad;
            index <= 4'd0;
            state <= StData;
          end
        end

        StData: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            shift[index[2:0]] <= rxs;
            cnt               <= FullLoad;
            index             <= index + 4'd1;
            if (index == 4'd7) begin
              state <= StStop;
            end
          end
        end

        StStop: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (rxs) begin
            // Newest byte wins; flag the loss if the old one was unread.
            rxdata  <= shift;
            rxvalid <= 1'b1;
            if (rxvalid && !rxack) begin
              rxoverrun <= 1'b1;
            end
            state <= StIdle;
          end else begin
            rxerror <= 1'b1;
            state   <= StBreak;
          end
        end

        StBreak: begin
          // Hold off until the line returns high so a stuck-low line is
          // not decoded as a stream of frames.
          if (rxs) begin
            state <= StIdle;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: directed bench for uart_receive at 16 and 4 clocks per bit.
module tb_uart_receive;

  logic       clock;
  logic       reset;
  logic       rx16;
  logic       rx4;
  logic       ack16;
  logic       ack4;
  logic [7:0] rxdata16;
  logic [7:0] rxdata4;
  logic       rxvalid16;
  logic       rxvalid4;
  logic       rxerror16;
  logic       rxerror4;
  logic       rxoverrun16;
  logic       rxoverrun4;

  int n_checks = 0;
  int n_fail   = 0;
  int err16    = 0;
  int err4     = 0;

  uart_receive #(
    .clockperbit(16)
  ) dut16 (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx16),
    .rxdata   (rxdata16),
    .rxvalid  (rxvalid16),
    .rxack    (ack16),
    .rxerror  (rxerror16),
    .rxoverrun(rxoverrun16)
  );

  uart_receive #(
    .clockperbit(4)
  ) dut4 (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx4),
    .rxdata   (rxdata4),
    .rxvalid  (rxvalid4),
    .rxack    (ack4),
    .rxerror  (rxerror4),
    .rxoverrun(rxoverrun4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count error pulses away from the active edge.
  always @(negedge clock) begin
    if (rxerror16) err16 = err16 + 1;
    if (rxerror4)  err4  = err4 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clock);
  endtask

  // Drive one frame, one line change per falling clock edge. Returns with the
  // stop bit just driven, so a following call sends back-to-back.
  // With chk_lat, checks that rxvalid rises exactly on edge 3+H+9N after the
  // fall (2 synchronizer edges + IDLE detection edge, then H + 9N).
  task automatic send(input logic [7:0] data, input logic stop, input bit sel4,
                      input bit chk_lat);
    int          n;
    int          stop_edge;
    logic [9:0]  line;
    n         = sel4 ? 4 : 16;
    stop_edge = 3 + n / 2 + 9 * n;
    line      = {stop, data, 1'b0};
    for (int c = 0; c < 10 * n; c++) begin
      @(negedge clock);
      if (chk_lat && c == stop_edge - 1) check_eq("lat_before_stop", rxvalid16, 1'b0);
      if (chk_lat && c == stop_edge) begin
        check_eq("lat_at_stop", rxvalid16, 1'b1);
        check_eq("lat_data", rxdata16, 8'hA5);
      end
      if (sel4) rx4 = line[c / n];
      else      rx16 = line[c / n];
    end
  endtask

  task automatic pulse_ack16;
    @(negedge clock);
    ack16 = 1'b1;
    @(negedge clock);
    ack16 = 1'b0;
  endtask

  task automatic pulse_ack4;
    @(negedge clock);
    ack4 = 1'b1;
    @(negedge clock);
    ack4 = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    rx16  = 1'b1;
    rx4   = 1'b1;
    ack16 = 1'b0;
    ack4  = 1'b0;
    idle(3);
    check_eq("rst_data", rxdata16, 8'h00);
    check_eq("rst_valid", rxvalid16, 1'b0);
    check_eq("rst_error", rxerror16, 1'b0);
    check_eq("rst_overrun", rxoverrun16, 1'b0);
    reset = 1'b1;
    idle(5);

    // A5 with exact completion timing, then ack.
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    idle(4);
    check_eq("a5_data", rxdata16, 8'hA5);
    check_eq("a5_err", err16, 0);
    pulse_ack16;
    check_eq("a5_ack_valid", rxvalid16, 1'b0);

    // 5-cycle glitch is rejected, then 3C.
    @(negedge clock);
    rx16 = 1'b0;
    idle(5);
    rx16 = 1'b1;
    idle(40);
    check_eq("glitch_valid", rxvalid16, 1'b0);
    check_eq("glitch_err", err16, 0);
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(4);
    check_eq("3c_data", rxdata16, 8'h3C);
    check_eq("3c_valid", rxvalid16, 1'b1);
    pulse_ack16;

    // Framing error with a held-low line: one error pulse, no frame.
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    idle(40);
    rx16 = 1'b1;
    idle(20);
    check_eq("brk_err_count", err16, 1);
    check_eq("brk_valid", rxvalid16, 1'b0);
    check_eq("brk_data_kept", rxdata16, 8'h3C);
    send(8'h01, 1'b1, 1'b0, 1'b0);
    idle(4);
    check_eq("01_data", rxdata16, 8'h01);
    check_eq("01_valid", rxvalid16, 1'b1);
    check_eq("01_err_count", err16, 1);
    pulse_ack16;

    // Back-to-back without ack: overrun, newest byte wins.
    idle(5);
    send(8'h11, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0, 1'b0);
    idle(4);
    check_eq("ovr_data", rxdata16, 8'h22);
    check_eq("ovr_valid", rxvalid16, 1'b1);
    check_eq("ovr_flag", rxoverrun16, 1'b1);
    pulse_ack16;
    check_eq("ovr_ack_valid", rxvalid16, 1'b0);
    check_eq("ovr_ack_flag", rxoverrun16, 1'b0);

    // Reset during data bit 4 of 55, then 0F.
    idle(5);
    for (int c = 0; c < 16 * 5 + 8; c++) begin
      logic [9:0] line55;
      line55 = {1'b1, 8'h55, 1'b0};
      @(negedge clock);
      rx16 = line55[c / 16];
    end
    @(negedge clock);
    reset = 1'b0;
    rx16  = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_data", rxdata16, 8'h00);
    check_eq("mid_rst_valid", rxvalid16, 1'b0);
    check_eq("mid_rst_overrun", rxoverrun16, 1'b0);
    idle(3);
    reset = 1'b1;
    idle(200);
    check_eq("post_rst_valid", rxvalid16, 1'b0);
    send(8'h0F, 1'b1, 1'b0, 1'b0);
    idle(4);
    check_eq("0f_data", rxdata16, 8'h0F);
    check_eq("0f_valid", rxvalid16, 1'b1);
    check_eq("0f_err_count", err16, 1);

    // clockperbit = 4.
    idle(5);
    send(8'h00, 1'b1, 1'b1, 1'b0);
    idle(4);
    check_eq("n4_00_valid", rxvalid4, 1'b1);
    check_eq("n4_00_data", rxdata4, 8'h00);
    pulse_ack4;
    check_eq("n4_ack_valid", rxvalid4, 1'b0);
    send(8'h80, 1'b1, 1'b1, 1'b0);
    idle(4);
    check_eq("n4_80_data", rxdata4, 8'h80);
    check_eq("n4_80_valid", rxvalid4, 1'b1);
    check_eq("n4_err_count", err4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
